// File: rtl/batch_lane_sched.sv
// Sample ring buffer and backward-pass scheduler for the batch estimator.
// Incoming samples fill a 4-segment ring RAM. Each completed segment after the
// first launches a backward read pass on one of two alternating lanes. A pass
// reads the new segment (lookahead) followed by the previous segment (result span).
module batch_lane_sched #(
    parameter int DEPTH  = 192,
    parameter int N      = 3,
    parameter int ADDR_W = $clog2(4*DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      in,
    input  logic              in_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              rdA_en,
    output logic [ADDR_W-1:0] rdA_addr,
    output logic              resA_en,
    output logic              firstA,
    output logic              lastA,
    output logic              rdB_en,
    output logic [ADDR_W-1:0] rdB_addr,
    output logic              resB_en,
    output logic              firstB,
    output logic              lastB,
    output logic              overrun
);

    localparam int OFF_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(2*DEPTH);

    localparam logic [OFF_W-1:0]  OFF_LAST   = OFF_W'(DEPTH-1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(2*DEPTH-1);
    localparam logic [CNT_W-1:0]  CNT_PENULT = CNT_W'(2*DEPTH-2);
    localparam logic [CNT_W-1:0]  CNT_RES    = CNT_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(4*DEPTH-1);

    typedef enum logic {IDLE, RUN} lane_state_t;

    logic [OFF_W-1:0] off;
    logic [1:0]       seg;
    logic             primed;
    logic             next_b;
    logic             pend_a, pend_b;
    logic [1:0]       base_a, base_b;
    lane_state_t      st_a, st_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    logic launch;
    logic busy_a, busy_b;

    // Highest address of segment k, where a backward pass begins.
    function automatic logic [ADDR_W-1:0] seg_top(input logic [1:0] k);
        return ADDR_W'(int'(k) * DEPTH + DEPTH - 1);
    endfunction

    // A lane is busy unless it will have issued its final read by the time a
    // freshly launched pass would issue its first one (two cycles later).
    always_comb begin
        launch = in_valid && (off == OFF_LAST);
        busy_a = pend_a || ((st_a == RUN) && (cnt_a != CNT_PENULT) && (cnt_a != CNT_LAST));
        busy_b = pend_b || ((st_b == RUN) && (cnt_b != CNT_PENULT) && (cnt_b != CNT_LAST));
    end

    // Write path, segment bookkeeping and lane launch with a one-cycle pending stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            off     <= '0;
            seg     <= '0;
            primed  <= 1'b0;
            next_b  <= 1'b0;
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
            base_a  <= '0;
            base_b  <= '0;
            overrun <= 1'b0;
        end else begin
            wr_en  <= in_valid;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            if (in_valid) begin
                wr_addr <= ADDR_W'(int'(seg) * DEPTH + int'(off));
                wr_data <= in;
                if (off == OFF_LAST) begin
                    off <= '0;
                    seg <= seg + 2'd1;
                end else begin
                    off <= off + 1'b1;
                end
            end
            if (launch) begin
                if (!primed) begin
                    primed <= 1'b1;
                end else begin
                    next_b <= !next_b;
                    if (next_b) begin
                        if (busy_b) begin
                            overrun <= 1'b1;
                        end else begin
                            pend_b <= 1'b1;
                            base_b <= seg;
                        end
                    end else begin
                        if (busy_a) begin
                            overrun <= 1'b1;
                        end else begin
                            pend_a <= 1'b1;
                            base_a <= seg;
                        end
                    end
                end
            end
        end
    end

    // Lane A pass FSM: 2*DEPTH descending reads, result span in the second half.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_a     <= IDLE;
            cnt_a    <= '0;
            rdA_en   <= 1'b0;
            rdA_addr <= '0;
            resA_en  <= 1'b0;
            firstA   <= 1'b0;
            lastA    <= 1'b0;
        end else if (pend_a) begin
            st_a     <= RUN;
            cnt_a    <= '0;
            rdA_en   <= 1'b1;
            rdA_addr <= seg_top(base_a);
            resA_en  <= 1'b0;
            firstA   <= 1'b1;
            lastA    <= 1'b0;
        end else if (st_a == RUN) begin
            firstA <= 1'b0;
            if (cnt_a == CNT_LAST) begin
                st_a    <= IDLE;
                rdA_en  <= 1'b0;
                resA_en <= 1'b0;
                lastA   <= 1'b0;
            end else begin
                cnt_a    <= cnt_a + 1'b1;
                rdA_addr <= (rdA_addr == '0) ? ADDR_LAST : rdA_addr - 1'b1;
                resA_en  <= (cnt_a >= CNT_RES);
                lastA    <= (cnt_a == CNT_PENULT);
            end
        end
    end

    // Lane B pass FSM, identical to lane A and fully independent of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_b     <= IDLE;
            cnt_b    <= '0;
            rdB_en   <= 1'b0;
            rdB_addr <= '0;
            resB_en  <= 1'b0;
            firstB   <= 1'b0;
            lastB    <= 1'b0;
        end else if (pend_b) begin
            st_b     <= RUN;
            cnt_b    <= '0;
            rdB_en   <= 1'b1;
            rdB_addr <= seg_top(base_b);
            resB_en  <= 1'b0;
            firstB   <= 1'b1;
            lastB    <= 1'b0;
        end else if (st_b == RUN) begin
            firstB <= 1'b0;
            if (cnt_b == CNT_LAST) begin
                st_b    <= IDLE;
                rdB_en  <= 1'b0;
                resB_en <= 1'b0;
                lastB   <= 1'b0;
            end else begin
                cnt_b    <= cnt_b + 1'b1;
                rdB_addr <= (rdB_addr == '0) ? ADDR_LAST : rdB_addr - 1'b1;
                resB_en  <= (cnt_b >= CNT_RES);
                lastB    <= (cnt_b == CNT_PENULT);
            end
        end
    end

    // With at most one sample per cycle a launch can never find its lane busy.
    overrun_never : assert property (@(posedge clk) disable iff (rst)
        !(launch && primed && (next_b ? busy_b : busy_a)));

endmodule

// File: tb/tb_batch_lane_sched.sv
// Directed testbench for batch_lane_sched with DEPTH=4, N=3 (16-entry ring).
module tb_batch_lane_sched;

    logic       clk;
    logic       rst;
    logic [2:0] in;
    logic       in_valid;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_data;
    logic       rdA_en, resA_en, firstA, lastA;
    logic [3:0] rdA_addr;
    logic       rdB_en, resB_en, firstB, lastB;
    logic [3:0] rdB_addr;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    batch_lane_sched #(.DEPTH(4), .N(3)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rdA_en(rdA_en), .rdA_addr(rdA_addr), .resA_en(resA_en), .firstA(firstA), .lastA(lastA),
        .rdB_en(rdB_en), .rdB_addr(rdB_addr), .resB_en(resB_en), .firstB(firstB), .lastB(lastB),
        .overrun(overrun)
    );

    wire [24:0] all_out = {wr_en, wr_addr, wr_data, rdA_en, rdA_addr, resA_en, firstA, lastA,
                           rdB_en, rdB_addr, resB_en, firstB, lastB, overrun};

    // Continuous stream of samples 0..19 (sample s in cycle s). Launches:
    // s=7 -> A reads 7..0 at cycles 9..16, s=11 -> B reads 11..4 at 13..20,
    // s=15 -> A reads 15..8 at 17..24, s=19 -> B reads 3,2,1,0,15,14,13,12 at 21..28.
    int expA [0:30] = '{-1,-1,-1,-1,-1,-1,-1,-1,-1,
                        7,6,5,4,3,2,1,0,15,14,13,12,11,10,9,8,
                        -1,-1,-1,-1,-1,-1};
    int expB [0:30] = '{-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,
                        11,10,9,8,7,6,5,4,3,2,1,0,15,14,13,12,
                        -1,-1};
    // {res, first, last} per cycle
    logic [2:0] flgA [0:30] = '{0,0,0,0,0,0,0,0,0,
                                3'b010,0,0,0,3'b100,3'b100,3'b100,3'b101,
                                3'b010,0,0,0,3'b100,3'b100,3'b100,3'b101,
                                0,0,0,0,0,0};
    logic [2:0] flgB [0:30] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,
                                3'b010,0,0,0,3'b100,3'b100,3'b100,3'b101,
                                3'b010,0,0,0,3'b100,3'b100,3'b100,3'b101,
                                0,0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in = '0;
        step;
        step;
        rst = 1'b0;
    endtask

    // Reset held with valid input: everything stays zero; first write after release is addr 0.
    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b1;
        in = 3'd5;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (all_out !== 25'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle=%0d got=%h exp=0", i, all_out);
            end
        end
        rst = 1'b0;
        step;
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 3'd5}) begin
            errors++;
            $display("[TB] FAIL reset_first_write got en=%b addr=%0d data=%0d exp en=1 addr=0 data=5",
                     wr_en, wr_addr, wr_data);
        end
        in_valid = 1'b0;
        do_reset;
    endtask

    // Priming, first pass, overlapping lanes, back-to-back passes and address wrap.
    task automatic test_stream;
        logic exp_en;
        for (int c = 0; c < 31; c++) begin
            in_valid = (c < 20);
            in = 3'(c);
            exp_en = (c >= 1) && (c <= 20);
            checks++;
            if (wr_en !== exp_en) begin
                errors++;
                $display("[TB] FAIL stream_wr_en c=%0d got=%b exp=%b", c, wr_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (wr_addr !== 4'((c-1) % 16) || wr_data !== 3'(c-1)) begin
                    errors++;
                    $display("[TB] FAIL stream_wr c=%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                             c, wr_addr, wr_data, (c-1) % 16, (c-1) % 8);
                end
            end
            checks++;
            if (rdA_en !== (expA[c] >= 0)) begin
                errors++;
                $display("[TB] FAIL stream_rdA_en c=%0d got=%b exp=%b", c, rdA_en, expA[c] >= 0);
            end
            if (expA[c] >= 0) begin
                checks++;
                if (rdA_addr !== 4'(expA[c])) begin
                    errors++;
                    $display("[TB] FAIL stream_rdA_addr c=%0d got=%0d exp=%0d", c, rdA_addr, expA[c]);
                end
            end
            checks++;
            if ({resA_en, firstA, lastA} !== flgA[c]) begin
                errors++;
                $display("[TB] FAIL stream_flagsA c=%0d got=%b exp=%b", c, {resA_en, firstA, lastA}, flgA[c]);
            end
            checks++;
            if (rdB_en !== (expB[c] >= 0)) begin
                errors++;
                $display("[TB] FAIL stream_rdB_en c=%0d got=%b exp=%b", c, rdB_en, expB[c] >= 0);
            end
            if (expB[c] >= 0) begin
                checks++;
                if (rdB_addr !== 4'(expB[c])) begin
                    errors++;
                    $display("[TB] FAIL stream_rdB_addr c=%0d got=%0d exp=%0d", c, rdB_addr, expB[c]);
                end
            end
            checks++;
            if ({resB_en, firstB, lastB} !== flgB[c]) begin
                errors++;
                $display("[TB] FAIL stream_flagsB c=%0d got=%b exp=%b", c, {resB_en, firstB, lastB}, flgB[c]);
            end
            checks++;
            if (overrun !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stream_overrun c=%0d got=%b exp=0", c, overrun);
            end
            step;
        end
        in_valid = 1'b0;
    endtask

    // Valid pattern 1,0,0,1: samples land at cycles 0,3,4,7,8,11,12,15, so sample 7
    // arrives at cycle 15 and lane A reads 7..0 at cycles 17..24 (result span 21..24).
    task automatic test_gapped_valid;
        logic       exp_en;
        logic [3:0] exp_addr;
        int         nsamp;
        logic       v;
        do_reset;
        exp_en = 1'b0;
        exp_addr = '0;
        nsamp = 0;
        for (int c = 0; c < 27; c++) begin
            v = (c < 16) && ((c % 4 == 0) || (c % 4 == 3));
            in_valid = v;
            in = 3'(c);
            checks++;
            if (wr_en !== exp_en || (exp_en && wr_addr !== exp_addr)) begin
                errors++;
                $display("[TB] FAIL gapped_wr c=%0d got en=%b addr=%0d exp en=%b addr=%0d",
                         c, wr_en, wr_addr, exp_en, exp_addr);
            end
            checks++;
            if (rdA_en !== ((c >= 17) && (c <= 24)) || rdB_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL gapped_rd_en c=%0d got A=%b B=%b exp A=%b B=0",
                         c, rdA_en, rdB_en, (c >= 17) && (c <= 24));
            end
            if (c >= 17 && c <= 24) begin
                checks++;
                if (rdA_addr !== 4'(24 - c) || {resA_en, firstA, lastA} !== {c >= 21, c == 17, c == 24}) begin
                    errors++;
                    $display("[TB] FAIL gapped_laneA c=%0d got addr=%0d flags=%b exp addr=%0d flags=%b",
                             c, rdA_addr, {resA_en, firstA, lastA}, 24 - c, {c >= 21, c == 17, c == 24});
                end
            end
            exp_en = v;
            if (v) begin
                exp_addr = 4'(nsamp);
                nsamp++;
            end
            step;
        end
        in_valid = 1'b0;
    endtask

    // Reset while lane A sits on address 5: the pass dies without lastA, and
    // a new launch needs two fresh segments (re-prime) before it appears.
    task automatic test_mid_reset;
        do_reset;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in = 3'(c);
            if (c == 11) begin
                checks++;
                if (rdA_en !== 1'b1 || rdA_addr !== 4'd5) begin
                    errors++;
                    $display("[TB] FAIL midrst_before c=%0d got en=%b addr=%0d exp en=1 addr=5", c, rdA_en, rdA_addr);
                end
                rst = 1'b1;
                in_valid = 1'b0;
            end
            step;
        end
        rst = 1'b0;
        checks++;
        if (all_out !== 25'd0) begin
            errors++;
            $display("[TB] FAIL midrst_after got=%h exp=0", all_out);
        end
        for (int c = 12; c < 23; c++) begin
            in_valid = (c < 20);
            in = 3'(c);
            if (c == 13 || c == 20) begin
                checks++;
                if (wr_en !== 1'b1 || wr_addr !== 4'(c - 13)) begin
                    errors++;
                    $display("[TB] FAIL midrst_wr c=%0d got en=%b addr=%0d exp en=1 addr=%0d", c, wr_en, wr_addr, c - 13);
                end
            end
            if (c <= 20) begin
                checks++;
                if (rdA_en !== 1'b0 || rdB_en !== 1'b0 || lastA !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midrst_idle c=%0d got A=%b B=%b lastA=%b exp all 0", c, rdA_en, rdB_en, lastA);
                end
            end else begin
                checks++;
                if (rdA_en !== 1'b1 || rdA_addr !== 4'(28 - c) || firstA !== (c == 21)) begin
                    errors++;
                    $display("[TB] FAIL midrst_relaunch c=%0d got en=%b addr=%0d first=%b exp en=1 addr=%0d first=%b",
                             c, rdA_en, rdA_addr, firstA, 28 - c, c == 21);
                end
            end
            step;
        end
        in_valid = 1'b0;
    endtask

    // Sequence of scenarios, then the summary.
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in = '0;
        test_reset;
        test_stream;
        test_gapped_valid;
        test_mid_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
